// File: rtl/apb_cmd_master.sv
// APB master sequencer: queues register commands (write/read/set/clear) and runs each one
// as APB setup/access phases, with read-modify-write done as a locked read then write.
module apb_cmd_master #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic [31:0] paddr_o,
    output logic [31:0] pwdata_o,
    output logic        pwrite_o,
    output logic        psel_o,
    output logic        penable_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    input  logic        pslverr_i
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {OpWrite, OpRead, OpSet, OpClr} op_e;
    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StRsp} state_e;

    logic [1:0]    fifo_op    [FIFO_DEPTH];
    logic [31:0]   fifo_addr  [FIFO_DEPTH];
    logic [31:0]   fifo_wdata [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push, pop;

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        wphase_q, wphase_d;
    logic [7:0]  tcnt_q, tcnt_d;

    assign req_ready_o = (count_q != FULL);
    assign push        = req_valid_i && req_ready_o;
    assign pop         = (state_q == StIdle) && (count_q != '0);
    assign busy_o      = (state_q != StIdle) || (count_q != '0);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_op[wr_ptr_q]    <= req_op_i;
            fifo_addr[wr_ptr_q]  <= req_addr_i;
            fifo_wdata[wr_ptr_q] <= req_wdata_i;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            op_q     <= OpWrite;
            addr_q   <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            wphase_q <= 1'b0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            wphase_q <= wphase_d;
            tcnt_q   <= tcnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        wphase_d    = wphase_q;
        tcnt_d      = tcnt_q;
        psel_o      = 1'b0;
        penable_o   = 1'b0;
        pwrite_o    = 1'b0;
        paddr_o     = '0;
        pwdata_o    = '0;
        rsp_valid_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    op_d     = op_e'(fifo_op[rd_ptr_q]);
                    addr_d   = fifo_addr[rd_ptr_q];
                    data_d   = fifo_wdata[rd_ptr_q];
                    wphase_d = (fifo_op[rd_ptr_q] == OpWrite);
                    rdata_d  = '0;
                    err_d    = 1'b0;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                psel_o   = 1'b1;
                paddr_o  = addr_q;
                pwrite_o = wphase_q;
                pwdata_o = wphase_q ? data_q : '0;
                tcnt_d   = '0;
                state_d  = StAccess;
            end
            StAccess: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                paddr_o   = addr_q;
                pwrite_o  = wphase_q;
                pwdata_o  = wphase_q ? data_q : '0;
                if (pready_i) begin
                    if (wphase_q || op_q == OpRead) begin
                        if (op_q == OpRead) rdata_d = prdata_i;
                        err_d   = pslverr_i;
                        state_d = StRsp;
                    end else if (pslverr_i) begin
                        // Failed RMW read: abandon without touching the register.
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = StRsp;
                    end else begin
                        rdata_d  = prdata_i;
                        data_d   = (op_q == OpSet) ? (prdata_i | data_q) : (prdata_i & ~data_q);
                        wphase_d = 1'b1;
                        state_d  = StSetup;
                    end
                end else if (TMO != 8'd0 && tcnt_q + 8'd1 == TMO) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = StRsp;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            StRsp: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end
endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: behavioural APB slave, command-level reference model,
// directed vector table plus reset, FIFO-full and randomized sequences.
module tb_apb_cmd_master;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 4;
    localparam logic [1:0] OP_WR = 2'd0, OP_RD = 2'd1, OP_SET = 2'd2, OP_CLR = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic [31:0] paddr, pwdata, prdata;
    logic        pwrite, psel, penable, pready, pslverr;

    always #5 clk = ~clk;

    apb_cmd_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .busy_o(busy),
        .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite), .psel_o(psel),
        .penable_o(penable), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave register space and the model's own copy of it.
    logic [31:0] smem [logic [31:0]];
    logic [31:0] rmem [logic [31:0]];
    logic [31:0] rmem_save [logic [31:0]];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction
    function automatic logic [31:0] srd(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : init_val(a);
    endfunction
    function automatic logic [31:0] rrd(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : init_val(a);
    endfunction

    int          waits_cfg = 0;
    bit          wait_rand = 1'b0;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;
    function automatic bit s_err(input logic [31:0] a);
        return err_en && (a == err_addr);
    endfunction

    typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; } xfer_t;
    typedef struct { logic [31:0] rdata; logic err; } rsp_t;
    xfer_t exp_xfer[$];
    rsp_t  exp_rsp[$];

    // Expected bus traffic and response of one command, from the command semantics alone.
    task automatic model_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] old;
        logic [31:0] nv;
        xfer_t x;
        rsp_t r;
        bit tmo;
        old = rrd(a);
        tmo = !wait_rand && (waits_cfg >= int'(TMO));
        r.rdata = 32'h0;
        r.err = 1'b1;
        if (!tmo) begin
            x.addr = a; x.wr = (op == OP_WR); x.wdata = (op == OP_WR) ? w : 32'h0;
            exp_xfer.push_back(x);
            if (op == OP_WR) begin
                r.err = s_err(a);
                if (!s_err(a)) rmem[a] = w;
            end else if (op == OP_RD) begin
                r.rdata = old;
                r.err = s_err(a);
            end else if (!s_err(a)) begin
                nv = (op == OP_SET) ? (old | w) : (old & ~w);
                x.wr = 1'b1; x.wdata = nv;
                exp_xfer.push_back(x);
                rmem[a] = nv;
                r.rdata = old;
                r.err = 1'b0;
            end
        end
        exp_rsp.push_back(r);
    endtask

    // APB slave: wait states and errors per configuration, pslverr noise while not ready.
    int          waits_left = 0;
    int          pen_cycles = 0;
    int          psel_cycles = 0;
    int          wr_xfers = 0;
    logic [31:0] last_pwdata = 32'h0;
    logic [31:0] s_addr, s_wdata;
    logic        s_write;
    logic        prev_psel = 1'b0;
    always @(negedge clk) begin
        xfer_t x;
        pready  = 1'b0;
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
        if (psel) psel_cycles++;
        if (psel && !penable) begin
            s_addr = paddr; s_write = pwrite; s_wdata = pwdata;
            waits_left = wait_rand ? int'($urandom_range(0, TMO - 1)) : waits_cfg;
        end else if (psel && penable) begin
            pen_cycles++;
            check("apb_setup_first", 32'(prev_psel), 32'd1);
            check("apb_stable", {paddr ^ s_addr} | {31'h0, pwrite ^ s_write} | (pwdata ^ s_wdata),
                  32'h0);
            if (waits_left > 0) begin
                waits_left--;
            end else begin
                pready  = 1'b1;
                prdata  = srd(paddr);
                pslverr = s_err(paddr);
                if (pwrite) begin
                    wr_xfers++;
                    last_pwdata = pwdata;
                    if (!pslverr) smem[paddr] = pwdata;
                end
                if (exp_xfer.size() == 0) begin
                    check("unexpected_xfer", paddr, 32'hFFFF_FFFF);
                end else begin
                    x = exp_xfer.pop_front();
                    check("xfer_addr", paddr, x.addr);
                    check("xfer_write", 32'(pwrite), 32'(x.wr));
                    check("xfer_wdata", pwdata, x.wdata);
                end
            end
        end
        prev_psel = psel;
    end

    bit rsp_rand = 1'b0;
    bit rsp_go = 1'b0;
    always @(negedge clk) begin
        rsp_t r;
        rsp_ready = rsp_rand ? 1'($urandom_range(0, 1)) : rsp_go;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_rsp.size() == 0) begin
                check("unexpected_rsp", rsp_rdata, 32'hFFFF_FFFF);
            end else begin
                r = exp_rsp.pop_front();
                check("rsp_rdata", rsp_rdata, r.rdata);
                check("rsp_err", 32'(rsp_err), 32'(r.err));
            end
        end
    end

    task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] w);
        int k = 0;
        req_op = op; req_addr = a; req_wdata = w; req_valid = 1'b1;
        while (!req_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) check("push_accept", 32'(req_ready), 32'd1);
        else model_cmd(op, a, w);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int limit);
        int k = 0;
        rsp_go = 1'b1;
        while ((exp_rsp.size() != 0 || rsp_valid || busy) && k < limit) begin
            @(negedge clk);
            k++;
        end
        rsp_go = 1'b0;
        check(name, 32'(exp_rsp.size()), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [1:0] op; logic [31:0] addr; logic [31:0] wdata; int waits; bit err;
        logic [31:0] exp_rdata; bit exp_err; int exp_lat; int exp_pen; int exp_wr;
        logic [31:0] exp_pwdata;
    } vec_t;
    localparam int NV = 11;
    vec_t vecs[NV];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pool[6];
        int lat, pen0, wr0, psel0, k;
        vec_t v;
        //          op      addr      wdata     wt   err exp_rdata     err lat pen wr  pwdata
        vecs[0]  = '{OP_WR,  32'h80, 32'h1,      0, 1'b0, 32'h0,       1'b0, 3, 1, 1, 32'h1};
        vecs[1]  = '{OP_SET, 32'hA4, 32'h101,    0, 1'b0, 32'h10,      1'b0, 5, 2, 1, 32'h111};
        vecs[2]  = '{OP_CLR, 32'h00, 32'h4,      0, 1'b1, 32'h0,       1'b1, 3, 1, 0, 32'h0};
        vecs[3]  = '{OP_RD,  32'h40, 32'h0,      3, 1'b0, 32'hCAFEF00D, 1'b0, 6, 4, 0, 32'h0};
        vecs[4]  = '{OP_RD,  32'h40, 32'h0,    255, 1'b0, 32'h0,       1'b1, 6, 4, 0, 32'h0};
        vecs[5]  = '{OP_RD,  32'h40, 32'h0,      4, 1'b0, 32'h0,       1'b1, 6, 4, 0, 32'h0};
        vecs[6]  = '{OP_CLR, 32'hA4, 32'h100,    0, 1'b0, 32'h111,     1'b0, 5, 2, 1, 32'h11};
        vecs[7]  = '{OP_WR,  32'h88, 32'h5,      0, 1'b1, 32'h0,       1'b1, 3, 1, 1, 32'h5};
        vecs[8]  = '{OP_SET, 32'hA4, 32'hF000,   1, 1'b0, 32'h11,      1'b0, 7, 4, 1, 32'hF011};
        vecs[9]  = '{OP_RD,  32'hA4, 32'h0,      0, 1'b1, 32'hF011,    1'b1, 3, 1, 0, 32'h0};
        vecs[10] = '{OP_RD,  32'h80, 32'h0,      0, 1'b0, 32'h1,       1'b0, 3, 1, 0, 32'h0};

        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_pwrite", 32'(pwrite), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        smem[32'hA4] = 32'h10;       rmem[32'hA4] = 32'h10;
        smem[32'h40] = 32'hCAFEF00D; rmem[32'h40] = 32'hCAFEF00D;
        smem[32'h00] = 32'h5555AAAA; rmem[32'h00] = 32'h5555AAAA;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            waits_cfg = v.waits; err_en = v.err; err_addr = v.addr;
            pen0 = pen_cycles; wr0 = wr_xfers;
            push(v.op, v.addr, v.wdata);
            lat = 0;
            while (!rsp_valid && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(v.exp_lat));
            check($sformatf("v%0d_rdata", i), rsp_rdata, v.exp_rdata);
            check($sformatf("v%0d_err", i), 32'(rsp_err), 32'(v.exp_err));
            check($sformatf("v%0d_penable_cycles", i), 32'(pen_cycles - pen0), 32'(v.exp_pen));
            check($sformatf("v%0d_writes", i), 32'(wr_xfers - wr0), 32'(v.exp_wr));
            if (v.exp_wr > 0) check($sformatf("v%0d_pwdata", i), last_pwdata, v.exp_pwdata);
            drain($sformatf("v%0d_drain", i), 20);
        end
        err_en = 1'b0;

        // Reset while the first of three commands sits in ACCESS.
        waits_cfg = 3;
        rmem_save = rmem;
        push(OP_RD, 32'h40, 32'h0);
        push(OP_WR, 32'h0C, 32'hDEAD);
        push(OP_WR, 32'h08, 32'h1);
        k = 0;
        while (!penable && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid_in_access", 32'(penable), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_psel", 32'(psel), 32'd0);
        check("rst_mid_penable", 32'(penable), 32'd0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_req_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        exp_rsp.delete();
        exp_xfer.delete();
        rmem = rmem_save;
        psel0 = psel_cycles;
        rsp_go = 1'b1;
        repeat (12) @(negedge clk);
        rsp_go = 1'b0;
        check("rst_mid_no_issue", 32'(psel_cycles - psel0), 32'd0);
        check("rst_mid_reg_0c", srd(32'h0C), init_val(32'h0C));

        // Five back-to-back pushes with responses blocked: one in flight, four queued.
        waits_cfg = 0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fifo_ready_%0d", i), 32'(req_ready), 32'd1);
            req_op = 2'(i % 4); req_addr = 32'h10 + 32'(4 * i); req_wdata = 32'h3 << i;
            req_valid = 1'b1;
            model_cmd(req_op, req_addr, req_wdata);
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("fifo_full_%0d", i), 32'(req_ready), 32'd0);
            @(negedge clk);
        end

        // Randomized traffic on top of the full FIFO; pointers wrap many times.
        pool = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h80, 32'h84};
        wait_rand = 1'b1; err_en = 1'b1; err_addr = 32'h84; rsp_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push(2'($urandom_range(0, 3)), pool[$urandom_range(0, 5)], $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        k = 0;
        while ((exp_rsp.size() != 0 || busy) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("rand_drain", 32'(exp_rsp.size()), 32'd0);
        check("rand_xfers_left", 32'(exp_xfer.size()), 32'd0);
        check("rand_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 6; i++) check($sformatf("mem_%0h", pool[i]), srd(pool[i]), rrd(pool[i]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
